// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - Funct3 operation codes (MUL .. REMU)
//   - FSM state enum (IDLE, CALC, FIXUP, DONE)
//   - decode helpers: is_div, is_mul_high, is_signed_a, is_signed_b
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  function automatic logic is_div(input logic [2:0] f);
    return (f == F_DIV) || (f == F_DIVU) || (f == F_REM) || (f == F_REMU);
  endfunction

  function automatic logic is_mul_high(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_MULHU);
  endfunction

  // MULHSU treats rs1 as signed and rs2 as unsigned.
  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   master (core side): drives Start, Funct3, SrcA, SrcB, Flush; reads Busy, Done, Result
//   slave  (unit side): the reverse
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, Funct3, SrcA, SrcB, Flush,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Flush,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_fsm.sv
// muldiv_fsm: control for muldiv_unit.
//   clk, rst : clock, async active-high reset
//   start    : request from the core
//   flush    : pipeline abort, overrides start
//   special  : request needs no iterations (div-by-zero / signed overflow)
//   busy     : registered, high in CALC and FIXUP
//   done     : registered, high in DONE
//   accept   : operands are captured at this edge
//   calc     : datapath iterates this cycle
//   fix_en   : result register is written this cycle
module muldiv_fsm
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  input  logic special,
  output logic busy,
  output logic done,
  output logic accept,
  output logic calc,
  output logic fix_en
);

  localparam int CW = $clog2(XLEN + 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Start is only honoured when idle or finishing; flush always wins.
  assign accept = start && !flush && (state == IDLE || state == DONE);
  assign calc   = (state == CALC);
  assign fix_en = (state == FIXUP) && !flush;

  // busy/done are registered alongside the state so they track its decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cnt  <= '0;
          done <= 1'b0;
          if (start) begin
            state <= special ? FIXUP : CALC;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          busy <= 1'b1;
          done <= 1'b0;
          if (cnt == CW'(XLEN - 1)) state <= FIXUP;
          else                      cnt   <= cnt + CW'(1);
        end
        FIXUP: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle.
//   clk, rst : clock, async active-high reset
//   bus      : muldiv_if slave (Start/Funct3/SrcA/SrcB/Flush in, Busy/Done/Result out)
// Operands are reduced to magnitudes at accept; CALC runs XLEN shift-add or
// restoring-divide steps; FIXUP re-applies the sign and writes Result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic busy, done, accept, calc, fix_en;

  // ---- accept-time decode -------------------------------------------------
  logic            sa, sb, in_dz, in_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs;

  assign sa      = is_signed_a(bus.Funct3) & bus.SrcA[XLEN-1];
  assign sb      = is_signed_b(bus.Funct3) & bus.SrcB[XLEN-1];
  assign a_abs   = sa ? -bus.SrcA : bus.SrcA;
  assign b_abs   = sb ? -bus.SrcB : bus.SrcB;
  assign in_dz   = is_div(bus.Funct3) && (bus.SrcB == '0);
  assign in_ovf  = ((bus.Funct3 == F_DIV) || (bus.Funct3 == F_REM)) &&
                   (bus.SrcA == MIN_NEG) && (bus.SrcB == '1);
  assign special = in_dz | in_ovf;

  muldiv_fsm #(.XLEN(XLEN)) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.Start),
    .flush   (bus.Flush),
    .special (special),
    .busy    (busy),
    .done    (done),
    .accept  (accept),
    .calc    (calc),
    .fix_en  (fix_en)
  );

  // ---- datapath registers -------------------------------------------------
  logic [2:0]        op;
  logic [XLEN-1:0]   a_raw, mcand, divisor, quo, rem, res;
  logic [2*XLEN-1:0] acc;        // {product high, multiplier/product low}
  logic              neg_q, neg_a, dz, ovf;

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_nx;
  assign addend = acc[0] ? mcand : '0;
  assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
  assign acc_nx = {sum, acc[XLEN-1:1]};

  // Restoring divide step on an XLEN+1-bit partial remainder. After the
  // restore the remainder is below the divisor, so XLEN bits hold it.
  logic [XLEN:0]   part;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx;
  assign part   = {rem, quo[XLEN-1]};
  assign ge     = (part >= {1'b0, divisor});
  assign rem_nx = ge ? XLEN'(part - {1'b0, divisor}) : part[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= '0;
      a_raw   <= '0;
      mcand   <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_a   <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
    end else if (accept) begin
      op      <= bus.Funct3;
      a_raw   <= bus.SrcA;
      mcand   <= a_abs;
      divisor <= b_abs;
      neg_q   <= sa ^ sb;
      neg_a   <= sa;
      dz      <= in_dz;
      ovf     <= in_ovf;
      acc     <= {{XLEN{1'b0}}, b_abs};
      quo     <= a_abs;
      rem     <= '0;
    end else if (calc) begin
      if (is_div(op)) begin
        rem <= rem_nx;
        quo <= quo_nx;
      end else begin
        acc <= acc_nx;
      end
    end
  end

  // ---- sign fix and output select ----------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_s, r_s, fix;
  assign prod = neg_q ? -acc : acc;
  assign q_s  = neg_q ? -quo : quo;
  assign r_s  = neg_a ? -rem : rem;

  // op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    fix = '0;
    if (!is_div(op))       fix = is_mul_high(op) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (dz)           fix = op[1] ? a_raw : '1;
    else if (ovf)          fix = op[1] ? '0 : a_raw;
    else                   fix = op[1] ? r_s : q_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         res <= '0;
    else if (fix_en) res <= fix;
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = res;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RV32M multiply/divide unit that sits beside the ALU in the execute stage. It accepts one operation per start pulse and computes it over several cycles using shift-add for multiply and restoring division for divide. While working it raises a stall to the core, then pulses done with a registered result. Width is parametrised so the same block serves the 32-bit core and narrower test builds.

## Interface
- XLEN, default 32: operand/result width; even, ≥ 8.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled on a rising edge while in IDLE or DONE.
- Funct3  in  3  op code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  XLEN  rs1 operand (multiplicand/dividend).
- SrcB  in  XLEN  rs2 operand (multiplier/divisor).
- Flush  in  1  synchronous abort from the pipeline.
- Busy  out  1  high in CALC and FIXUP; the core stalls on it.
- Done  out  1  one-cycle pulse in the DONE state.
- Result  out  XLEN  registered result; holds until the next result is written.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE + Start:
  - Capture Funct3.
  - Capture |SrcA| and |SrcB| per the op's signedness (MULHSU: A signed, B unsigned).
  - Record the result sign, then go to CALC with counter = 0.
- Special cases bypass CALC and go straight to FIXUP:
  - divide-by-zero (SrcB = 0, any div/rem op);
  - signed overflow (DIV/REM with SrcA = 2^(XLEN-1) and SrcB = all ones).
- CALC runs exactly XLEN iterations, one bit per cycle; counter width is $clog2(XLEN+1).
  - Multiply: 2·XLEN-bit accumulator, unsigned magnitudes.
  - Divide: XLEN-bit quotient plus (XLEN+1)-bit partial remainder.
  - After iteration XLEN−1, go to FIXUP.
- FIXUP applies the sign and selects the output, then writes Result and goes to DONE.
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half of the product.
  - Quotient sign = sign(A) XOR sign(B); remainder takes sign(A).
  - Divide-by-zero: quotient = all ones, remainder = SrcA.
  - Overflow: quotient = SrcA, remainder = 0.
- DONE: Done = 1 for one cycle. Next state is CALC/FIXUP if Start is high, otherwise IDLE.
- Start during CALC/FIXUP is ignored; the operands are not recaptured.
- Flush in any state: next state IDLE, no Done, Result unchanged.
  - Flush together with Start: Flush wins and the request is dropped.
- Reset (asynchronous): state IDLE, Busy 0, Done 0, Result 0, counter 0, datapath registers 0. Reset mid-operation abandons the operation with no Done.

## Timing
- Start sampled at edge 0 (normal path):
  - Busy high in cycles 1..XLEN+1.
  - FIXUP in cycle XLEN+1.
  - Done and new Result visible in cycle XLEN+2, i.e. 34 for XLEN = 32.
- Special-case path: FIXUP in cycle 1; Done and Result in cycle 2.
- Back-to-back: Start held high in the DONE cycle → the next op is in CALC in the following cycle, with no IDLE gap.
- Busy and Done come straight from state decode, registered-state only. Operand inputs are read only at the accepting edge and may change afterwards.

## Structure
- Package muldiv_pkg holds:
  - the Funct3 localparams (MUL … REMU);
  - the state enum typedef (IDLE, CALC, FIXUP, DONE);
  - helper functions is_div(funct3) and is_signed_a/b(funct3).
- One sub-module, muldiv_fsm: state register, iteration counter, Busy/Done decode and the Flush/Start arbitration.
- The datapath (accumulators, sign fix, result register) stays in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → Result 0xFFFFFFEB; Done in cycle 34; Busy high in cycles 1–33 only.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with Done in cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, each with Done in cycle 2.
- Flush in cycle 10 of a DIVU → Busy low in cycle 11, no Done, Result unchanged.
  - Start 100/7 in cycle 11 → Result 14 with Done 34 cycles later.
  - Start pulses during CALC are ignored.
- Async rst asserted mid-CALC without a clock edge → Busy, Done and Result 0 immediately.
  - After release, back-to-back MUL 3×4 then REMU 9/4 with Start held in DONE → 12 in cycle 34, then 1 in cycle 68.
